spi_master_param: RTL and testbench



---
 rtl/spi_master_pkg.sv | 19 +
 rtl/spi_clk_gen.sv | 46 ++++
 rtl/spi_master_param.sv | 164 ++++++++++++++++
 tb/tb_spi_master_param.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared state type, mode bit indices and chip-select width helper
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        XFER = 3'd2,
        LAG  = 3'd3,
        DONE = 3'd4
    } spi_state_t;

    localparam int CPOL_IDX = 1;
    localparam int CPHA_IDX = 0;

    function automatic int cs_sel_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK divider: half-period strobe, leading/trailing phase and SCLK level
module spi_clk_gen #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic toggle,
    input  logic load,
    input  logic load_cpol,
    output logic tick,
    output logic leading,
    output logic sclk
);
    localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;

    assign tick    = en && (cnt == CNT_MAX);
    assign leading = !phase;

    // Counter wraps exactly when the FSM changes state, so each state starts a fresh half-period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
            sclk  <= 1'b0;
        end else begin
            if (!en || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                phase <= 1'b0;
                sclk  <= load_cpol;
            end else if (tick && toggle) begin
                phase <= ~phase;
                sclk  <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master top; SPI_MASTER_LSB_FIRST_EN adds lsb_first port
module spi_master_param
    import spi_master_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 4,
    parameter int NUM_CS   = 2,
    localparam int CS_SEL_W = cs_sel_width(NUM_CS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic [DATA_W-1:0]   tx_data,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                lsb_first,
`endif
    output logic [DATA_W-1:0]   rx_data,
    output logic                busy,
    output logic                done,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [NUM_CS-1:0]   cs_n
);
    localparam int EC_W = $clog2(2 * DATA_W);
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * DATA_W - 1);

    spi_state_t        state, state_nxt;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [EC_W-1:0]   ecnt;
    logic              lsb_in, lsb_q;
    logic              cs_valid, accept, tick, leading, last_edge, in_xfer, clk_en;
    logic              sample, shift;
    logic [DATA_W-1:0] rx_data_d;
    logic [NUM_CS-1:0] cs_n_d;
    logic              busy_d, done_d, mosi_d;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign cs_valid  = ({1'b0, cs_sel} < (CS_SEL_W + 1)'(NUM_CS));
    assign accept    = (state == IDLE) && start && cs_valid;
    assign in_xfer   = (state == XFER);
    assign clk_en    = (state == LEAD) || in_xfer || (state == LAG);
    assign last_edge = (ecnt == EC_LAST);
    // CPHA=0 samples on leading edges, CPHA=1 on trailing; the launch edge is the other one.
    assign sample    = tick && in_xfer && (leading ^ mode_q[CPHA_IDX]);
    assign shift     = tick && in_xfer &&
                       (mode_q[CPHA_IDX] ? leading : (!leading && !last_edge));

    spi_clk_gen #(.HALF_DIV(HALF_DIV)) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (clk_en),
        .toggle    (in_xfer),
        .load      (accept),
        .load_cpol (mode[CPOL_IDX]),
        .tick      (tick),
        .leading   (leading),
        .sclk      (sclk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LEAD;
            LEAD:    if (tick) state_nxt = XFER;
            XFER:    if (tick && last_edge) state_nxt = LAG;
            LAG:     if (tick) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_d    = (state != IDLE);
        done_d    = (state == DONE);
        rx_data_d = (state == DONE) ? rx_sr : rx_data;
        cs_n_d    = cs_n;
        mosi_d    = mosi;
        if (accept) begin
            for (int i = 0; i < NUM_CS; i++) begin
                cs_n_d[i] = (CS_SEL_W'(i) != cs_sel);
            end
            if (!mode[CPHA_IDX]) begin
                mosi_d = first_bit(tx_data, lsb_in);
            end
        end else begin
            if (state == DONE) begin
                cs_n_d = '1;
            end
            if (shift) begin
                mosi_d = first_bit(tx_sr, lsb_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= '0;
            lsb_q  <= 1'b0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            ecnt   <= '0;
        end else begin
            if (accept) begin
                mode_q <= mode;
                lsb_q  <= lsb_in;
                tx_sr  <= mode[CPHA_IDX] ? tx_data : advance(tx_data, lsb_in);
                rx_sr  <= '0;
                ecnt   <= '0;
            end else begin
                if (shift) begin
                    tx_sr <= advance(tx_sr, lsb_q);
                end
                if (sample) begin
                    rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
                end
                if (tick && in_xfer) begin
                    ecnt <= ecnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= '1;
        end else begin
            rx_data <= rx_data_d;
            busy    <= busy_d;
            done    <= done_d;
            mosi    <= mosi_d;
            cs_n    <= cs_n_d;
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - scoreboard bench for spi_master_param with behavioural SPI slave
module tb_spi_master_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit, HALF_DIV=4, two chip selects
    logic       start0, cs_sel0, busy0, done0, sclk0, mosi0, miso0;
    logic [1:0] mode0, cs_n0;
    logic [7:0] tx0, rx0;
    // 12-bit, HALF_DIV=1, three chip selects, loopback
    logic        start1, busy1, done1, sclk1, mosi1;
    logic [1:0]  mode1, cs_sel1;
    logic [2:0]  cs_n1;
    logic [11:0] tx1, rx1;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb0, lsb1;
`endif

    logic       loop = 1'b1;
    logic [1:0] cur_mode = 2'b00;
    logic [7:0] s_tx = 8'h3C, s_sr = 8'h00, s_rx = 8'h00;
    logic       s_miso = 1'b0;
    assign miso0 = loop ? mosi0 : s_miso;

    spi_master_param #(.DATA_W(8), .HALF_DIV(4), .NUM_CS(2)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode0), .cs_sel(cs_sel0),
        .tx_data(tx0),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb0),
`endif
        .rx_data(rx0), .busy(busy0), .done(done0), .sclk(sclk0), .mosi(mosi0),
        .miso(miso0), .cs_n(cs_n0)
    );

    spi_master_param #(.DATA_W(12), .HALF_DIV(1), .NUM_CS(3)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode1), .cs_sel(cs_sel1),
        .tx_data(tx1),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb1),
`endif
        .rx_data(rx1), .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1),
        .miso(mosi1), .cs_n(cs_n1)
    );

    typedef struct {
        logic [11:0] rx;
        int          cyc;
        int          rises;
        logic [7:0]  slv;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model and scoreboard monitor for dut0
    logic act0, pc0 = 1'b0, ps0 = 1'b0, lead0;
    int   rises0 = 0;
    exp_t e0;
    always @(negedge clk) begin
        act0 = (cs_n0 != 2'b11);
        if (act0 && !pc0) begin
            rises0 = 0;
            s_rx   = 8'h00;
            s_sr   = s_tx;
            if (!cur_mode[0]) begin
                s_miso = s_sr[7];
                s_sr   = s_sr << 1;
            end
        end else if (act0 && sclk0 != ps0) begin
            lead0 = (ps0 == cur_mode[1]);
            if (!ps0) rises0++;
            if (lead0 ^ cur_mode[0]) begin
                s_rx = {s_rx[6:0], mosi0};
            end else begin
                s_miso = s_sr[7];
                s_sr   = s_sr << 1;
            end
        end
        pc0 = act0;
        ps0 = sclk0;
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("done0_unexpected", done0, 1'b0);
            end else begin
                e0 = q0.pop_front();
                check("rx0", rx0, e0.rx);
                check("done0_cycle", cyc, e0.cyc);
                check("rises0", rises0, e0.rises);
                check("slave_rx", s_rx, e0.slv);
            end
        end
    end

    // Scoreboard monitor for dut1
    logic act1, pc1 = 1'b0, ps1 = 1'b0;
    int   rises1 = 0;
    exp_t e1;
    always @(negedge clk) begin
        act1 = (cs_n1 != 3'b111);
        if (act1 && !pc1) rises1 = 0;
        else if (act1 && sclk1 && !ps1) rises1++;
        pc1 = act1;
        ps1 = sclk1;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("done1_unexpected", done1, 1'b0);
            end else begin
                e1 = q1.pop_front();
                check("rx1", rx1, e1.rx);
                check("done1_cycle", cyc, e1.cyc);
                check("rises1", rises1, e1.rises);
            end
        end
    end

    task automatic wait_q0(input int bound);
        int n = 0;
        while (q0.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("q0_drained", q0.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_q1(input int bound);
        int n = 0;
        while (q1.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("q1_drained", q1.size(), 0);
        @(negedge clk);
    endtask

    task automatic xfer0(input logic [1:0] m, input logic sel, input logic [7:0] tx,
                         input logic lp, input logic lsb, input logic [7:0] exp_rx,
                         input logic [7:0] exp_slv, input logic [1:0] exp_cs);
        exp_t e;
        cur_mode = m;
        loop     = lp;
        mode0    = m;
        cs_sel0  = sel;
        tx0      = tx;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb0     = lsb;
`else
        if (lsb) $display("lsb_first requested without SPI_MASTER_LSB_FIRST_EN");
`endif
        start0   = 1'b1;
        e.rx = {4'h0, exp_rx}; e.cyc = cyc + 1 + 73; e.rises = 8; e.slv = exp_slv;
        q0.push_back(e);
        @(negedge clk);
        start0 = 1'b0;
        check("cs_n0_active", cs_n0, exp_cs);
        check("sclk0_lead", sclk0, m[1]);
        wait_q0(200);
        check("sclk0_after", sclk0, m[1]);
    endtask

    initial begin
        exp_t e;
        int   acc;
        int   n;
        reset = 1'b1;
        start0 = 1'b0; mode0 = 2'b00; cs_sel0 = 1'b0; tx0 = 8'h00;
        start1 = 1'b0; mode1 = 2'b00; cs_sel1 = 2'b00; tx1 = 12'h000;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb0 = 1'b0; lsb1 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cs_n0", cs_n0, 2'b11);
        check("rst_busy0", busy0, 1'b0);
        check("rst_done0", done0, 1'b0);
        check("rst_sclk0", sclk0, 1'b0);
        check("rst_mosi0", mosi0, 1'b0);
        check("rst_rx0", rx0, 8'h00);
        check("rst_cs_n1", cs_n1, 3'b111);

        // mode 0 loopback on slave 1
        xfer0(2'b00, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 8'hA5, 2'b01);
        // all four modes against slave returning 0x3C
        xfer0(2'b00, 1'b0, 8'h96, 1'b0, 1'b0, 8'h3C, 8'h96, 2'b10);
        xfer0(2'b01, 1'b1, 8'h96, 1'b0, 1'b0, 8'h3C, 8'h96, 2'b01);
        xfer0(2'b10, 1'b0, 8'h96, 1'b0, 1'b0, 8'h3C, 8'h96, 2'b10);
        xfer0(2'b11, 1'b1, 8'h96, 1'b0, 1'b0, 8'h3C, 8'h96, 2'b01);

        // start held high: back-to-back, inputs changed mid-transfer
        cur_mode = 2'b00; loop = 1'b1; mode0 = 2'b00; cs_sel0 = 1'b0; tx0 = 8'h5A;
        start0 = 1'b1;
        acc = cyc + 1;
        e.rx = 12'h05A; e.cyc = acc + 73;  e.rises = 8; e.slv = 8'h5A; q0.push_back(e);
        e.rx = 12'h0C3; e.cyc = acc + 147; e.rises = 8; e.slv = 8'hC3; q0.push_back(e);
        @(negedge clk);
        tx0 = 8'hC3;
        n = 0;
        while (done0 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_busy", busy0, 1'b1);
        @(negedge clk);
        check("b2b_gap_busy", busy0, 1'b0);
        @(negedge clk);
        check("b2b_restart_busy", busy0, 1'b1);
        tx0 = 8'hFF; mode0 = 2'b11; start0 = 1'b0;
        repeat (10) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_q0(200);

`ifdef SPI_MASTER_LSB_FIRST_EN
        xfer0(2'b00, 1'b0, 8'h01, 1'b0, 1'b1, 8'h3C, 8'h80, 2'b10);
        xfer0(2'b00, 1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 8'h80, 2'b10);
        lsb0 = 1'b0;
`endif

        // 12-bit, HALF_DIV=1 loopback
        mode1 = 2'b00; cs_sel1 = 2'd1; tx1 = 12'hABC; start1 = 1'b1;
        e.rx = 12'hABC; e.cyc = cyc + 1 + 27; e.rises = 12; e.slv = 8'h00;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        check("cs_n1_active", cs_n1, 3'b101);
        wait_q1(100);

        // out-of-range chip select is ignored
        cs_sel1 = 2'd3; start1 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bad_sel_busy1", busy1, 1'b0);
            check("bad_sel_cs_n1", cs_n1, 3'b111);
        end
        start1 = 1'b0;
        repeat (20) @(negedge clk);

        // reset during XFER bit 3
        cur_mode = 2'b00; loop = 1'b1; mode0 = 2'b00; cs_sel0 = 1'b1; tx0 = 8'h77;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (28) @(negedge clk);
        check("pre_reset_busy0", busy0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_cs_n0", cs_n0, 2'b11);
        check("mid_rst_sclk0", sclk0, 1'b0);
        check("mid_rst_rx0", rx0, 8'h00);
        check("mid_rst_busy0", busy0, 1'b0);
        repeat (100) @(negedge clk);
        check("post_rst_busy0", busy0, 1'b0);
        check("final_q0", q0.size(), 0);
        check("final_q1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
